grid_loader: RTL and testbench
==============================

# grid_loader

Front-end stage that turns the ASCII puzzle stream ('@' = roll, '.' = empty, '\n' = end of row) into packed row bit-vectors. It writes them in TX_W-bit chunks into the grid bank that the pruning machines later read. The addressing and bit order match what the pruning machines expect: row index, column bit-offset, and cell j at bit j. It sits between the byte source (UART/FIFO) and the bank write port, and signals `done` when the grid is resident.

## Interface
- GRID_W, 144: row width in bits, a multiple of TX_W; cells beyond the line width are zero.
- TX_W, 16: bank write chunk width.
- DEPTH, 140: bank rows.
- ADDR_W, 8: row address width (≥ clog2(DEPTH+1)).
- COL_W, 8: column bit-offset width (≥ clog2(GRID_W)).
- clock  in  1  clock.
- reset  in  1  synchronous, active-high.
- start  in  1  one-cycle pulse: clear counters, enter FILL.
- byte_in  in  8  ASCII character.
- byte_valid  in  1  byte_in valid.
- byte_last  in  1  final byte of stream (qualifies byte_valid).
- byte_ready  out  1  loader accepts byte this cycle.
- wr_en  out  1  bank write request.
- wr_row  out  ADDR_W  target row.
- wr_col  out  COL_W  bit offset of chunk (multiple of TX_W).
- wr_data  out  TX_W  chunk; bit k = cell wr_col+k.
- wr_ack  in  1  bank accepted write.
- rows_loaded  out  ADDR_W  completed rows.
- width_out  out  COL_W  cells per row (first row's length).
- done  out  1  grid loaded, sticky until start/reset.
- error  out  1  malformed stream, sticky until start/reset.

## Operation
- States: IDLE, FILL, WRITE, PAD, DONE, ERR. `reset` → IDLE. `start` in any state → FILL, clearing all counters, chunk register and error.
- FILL: byte_ready=1. Each accepted byte is handled as follows:
  - '@' sets bit `bit_i` of the chunk; '.' clears it. Then bit_i++ and col_i++.
  - When bit_i reaches TX_W, go to WRITE with the chunk.
  - '\r' is ignored.
  - '\n' ends the row: go to WRITE if bit_i>0, otherwise go to PAD.
  - Any other byte → ERR.
- WRITE: wr_en=1, with wr_row=row_i, wr_col=chunk_base, wr_data=chunk, all held stable until wr_ack. On ack:
  - chunk_base+=TX_W, the chunk is cleared and bit_i=0.
  - Return to FILL, or go to PAD if the row has ended.
- PAD: write all-zero chunks for the remaining offsets up to GRID_W-TX_W, same handshake. When chunk_base reaches GRID_W:
  - row_i++ and rows_loaded++.
  - chunk_base=0 and col_i=0.
  - Go to FILL, or to DONE if the last byte has been seen.
- Width rule: the first '\n' latches width_out=col_i. A later row with col_i≠width_out → ERR.
- Overflow: a cell with col_i==GRID_W → ERR. A cell arriving with row_i==DEPTH → ERR.
- Empty line (a '\n' with col_i==0) is ignored: no row is written.
- byte_last: the byte is processed first. If the row is open (col_i>0), an implicit '\n' applies. Then go to DONE after the final pad; with no open row, go to DONE directly.
- DONE: done=1, byte_ready=0. ERR: error=1, byte_ready=0, wr_en=0.

## Timing
- Reset values: byte_ready=0, wr_en=0, wr_row=0, wr_col=0, wr_data=0, rows_loaded=0, width_out=0, done=0, error=0.
- byte_ready is registered. It drops the cycle after a byte that fills a chunk or ends a row, and stays low until the last ack of that chunk or pad.
- A write handshake completes in the cycle where wr_en&&wr_ack. wr_en falls the next cycle unless another chunk follows; back-to-back pad chunks keep wr_en high with wr_col advancing.
- Chunk-fill latency: wr_en rises 1 cycle after the accepting byte.
- Throughput with wr_ack tied high is one cell per cycle, plus 1 bubble per chunk.
- reset mid-write drops wr_en the next cycle; no partial state survives.
- start during WRITE abandons the pending write (wr_en=0 next cycle).
- wr_ack without wr_en is ignored.

## Test plan
- 3×3 grid "@.@\n.@.\n@@@\n", GRID_W=16, TX_W=8, wr_ack=1 → writes:
  - row0: 0x05 @col0, 0x00 @col8.
  - row1: 0x02, 0x00.
  - row2: 0x07, 0x00.
  - Then rows_loaded=3, width_out=3, done=1.
- 10-cell row of all '@' with TX_W=8 → chunks 0xFF @col0 then 0x03 @col8. Delay wr_ack by 5 cycles: wr_en/addr/data stay stable, byte_ready=0 throughout.
- Last row without a trailing '\n', byte_last on final '@' → row flushed and padded, done=1.
- Row 2 one cell shorter than row 1 → error=1 at its '\n', no further writes, byte_ready=0. A subsequent start clears error.
- Byte 'x' mid-row → error=1 next cycle. Separately, DEPTH+1 rows → error on first cell of row DEPTH.
- "\r\n" line endings and a blank line between rows → identical writes to the plain '\n' case, rows_loaded unchanged by the blank line.

Source files
------------

// File: rtl/grid_loader.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : grid_loader                                                |
// | Description : Converts an ASCII puzzle stream ('@' roll, '.' empty,      |
// |               '\n' end of row, '\r' ignored) into packed row vectors     |
// |               and writes them as TX_W-bit chunks into the grid bank.     |
// |               Cell j of a row lands at bit j of the row; cells past      |
// |               the line width are written as zero.                        |
// | Ports       : clock, reset      - clock, synchronous active-high reset   |
// |               start             - pulse: clear everything, begin loading |
// |               byte_in/valid/last/ready - byte stream handshake           |
// |               wr_en/row/col/data/ack   - bank write handshake            |
// |               rows_loaded, width_out   - completed rows, cells per row   |
// |               done, error              - sticky status flags             |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module grid_loader #(
   parameter int GRID_W = 144,
   parameter int TX_W   = 16,
   parameter int DEPTH  = 140,
   parameter int ADDR_W = 8,
   parameter int COL_W  = 8
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              start,
   input  logic [7:0]        byte_in,
   input  logic              byte_valid,
   input  logic              byte_last,
   output logic              byte_ready,
   output logic              wr_en,
   output logic [ADDR_W-1:0] wr_row,
   output logic [COL_W-1:0]  wr_col,
   output logic [TX_W-1:0]   wr_data,
   input  logic              wr_ack,
   output logic [ADDR_W-1:0] rows_loaded,
   output logic [COL_W-1:0]  width_out,
   output logic              done,
   output logic              error
);

   // Column-domain counters carry one extra bit so that a count equal to
   // GRID_W is representable even when GRID_W == 2**COL_W.
   localparam int                CW       = COL_W + 1;
   localparam logic [CW-1:0]     GRID_C   = CW'(GRID_W);
   localparam logic [CW-1:0]     TX_C     = CW'(TX_W);
   localparam logic [CW-1:0]     ONE_C    = CW'(1);
   localparam logic [ADDR_W-1:0] DEPTH_C  = ADDR_W'(DEPTH);
   localparam logic [ADDR_W-1:0] ROW_ONE  = ADDR_W'(1);
   localparam logic [TX_W-1:0]   BIT0     = TX_W'(1);
   localparam logic [7:0]        CH_ROLL  = 8'h40;
   localparam logic [7:0]        CH_EMPTY = 8'h2E;
   localparam logic [7:0]        CH_LF    = 8'h0A;
   localparam logic [7:0]        CH_CR    = 8'h0D;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_FILL  = 3'd1,
      S_WRITE = 3'd2,
      S_PAD   = 3'd3,
      S_DONE  = 3'd4,
      S_ERR   = 3'd5
   } state_t;

   state_t            state, state_nx;
   logic [TX_W-1:0]   chunk, chunk_nx;
   logic [CW-1:0]     bit_i, bit_nx;
   logic [CW-1:0]     col_i, col_nx;
   logic [CW-1:0]     base, base_nx;
   logic [CW-1:0]     width, width_nx;
   logic [ADDR_W-1:0] row_i, row_nx;
   logic              width_set, width_set_nx;
   logic              row_end, row_end_nx;     // current row closed, pad pending
   logic              last_seen, last_nx;      // final stream byte consumed

   logic              is_cell, is_lf, is_cr;
   logic [CW-1:0]     cell_bit, cell_col, base_adv;
   logic [TX_W-1:0]   cell_chunk;
   logic              finish_row;

   always_ff @(posedge clock) begin
      if (reset) begin
         state     <= S_IDLE;
         chunk     <= '0;
         bit_i     <= '0;
         col_i     <= '0;
         base      <= '0;
         width     <= '0;
         row_i     <= '0;
         width_set <= 1'b0;
         row_end   <= 1'b0;
         last_seen <= 1'b0;
      end else begin
         state     <= state_nx;
         chunk     <= chunk_nx;
         bit_i     <= bit_nx;
         col_i     <= col_nx;
         base      <= base_nx;
         width     <= width_nx;
         row_i     <= row_nx;
         width_set <= width_set_nx;
         row_end   <= row_end_nx;
         last_seen <= last_nx;
      end
   end

   always_comb begin
      state_nx     = state;
      chunk_nx     = chunk;
      bit_nx       = bit_i;
      col_nx       = col_i;
      base_nx      = base;
      width_nx     = width;
      row_nx       = row_i;
      width_set_nx = width_set;
      row_end_nx   = row_end;
      last_nx      = last_seen;
      finish_row   = 1'b0;

      is_cell  = (byte_in == CH_ROLL) || (byte_in == CH_EMPTY);
      is_lf    = (byte_in == CH_LF);
      is_cr    = (byte_in == CH_CR);
      base_adv = base + TX_C;

      // Effect of the incoming byte if it turns out to be a legal cell.
      cell_bit   = bit_i;
      cell_col   = col_i;
      cell_chunk = chunk;
      if (is_cell) begin
         cell_bit = bit_i + ONE_C;
         cell_col = col_i + ONE_C;
         if (byte_in == CH_ROLL) cell_chunk = chunk | (BIT0 << bit_i);
         else                    cell_chunk = chunk & ~(BIT0 << bit_i);
      end

      case (state)
         S_FILL: begin
            if (byte_valid) begin
               if (!(is_cell || is_lf || is_cr)) begin
                  state_nx = S_ERR;
               end else if (is_cell && ((col_i == GRID_C) || (row_i == DEPTH_C))) begin
                  state_nx = S_ERR;
               end else begin
                  bit_nx   = cell_bit;
                  col_nx   = cell_col;
                  chunk_nx = cell_chunk;
                  last_nx  = byte_last;
                  // The last byte closes an open row just like '\n' does.
                  if ((is_lf || byte_last) && (cell_col != '0)) begin
                     if (width_set && (cell_col != width)) begin
                        state_nx = S_ERR;
                     end else begin
                        width_set_nx = 1'b1;
                        width_nx     = cell_col;
                        row_end_nx   = 1'b1;
                        if (cell_bit != '0)        state_nx   = S_WRITE;
                        else if (base == GRID_C)   finish_row = 1'b1;  // row already fully written
                        else                       state_nx   = S_PAD;
                     end
                  end else if (cell_bit == TX_C) begin
                     state_nx = S_WRITE;
                  end else if (byte_last) begin
                     state_nx = S_DONE;
                  end
               end
            end
         end

         S_WRITE: begin
            if (wr_ack) begin
               base_nx  = base_adv;
               chunk_nx = '0;
               bit_nx   = '0;
               if (!row_end)                state_nx   = S_FILL;
               else if (base_adv == GRID_C) finish_row = 1'b1;
               else                         state_nx   = S_PAD;
            end
         end

         S_PAD: begin
            if (wr_ack) begin
               base_nx = base_adv;
               if (base_adv == GRID_C) finish_row = 1'b1;
            end
         end

         default: begin
         end
      endcase

      if (finish_row) begin
         row_nx     = row_i + ROW_ONE;
         base_nx    = '0;
         col_nx     = '0;
         bit_nx     = '0;
         chunk_nx   = '0;
         row_end_nx = 1'b0;
         state_nx   = last_nx ? S_DONE : S_FILL;
      end

      // start overrides everything, including a pending bank write.
      if (start) begin
         state_nx     = S_FILL;
         chunk_nx     = '0;
         bit_nx       = '0;
         col_nx       = '0;
         base_nx      = '0;
         width_nx     = '0;
         row_nx       = '0;
         width_set_nx = 1'b0;
         row_end_nx   = 1'b0;
         last_nx      = 1'b0;
      end
   end

   // All outputs are decoded straight from registered state.
   assign byte_ready  = (state == S_FILL);
   assign wr_en       = (state == S_WRITE) || (state == S_PAD);
   assign wr_row      = row_i;
   assign wr_col      = base[COL_W-1:0];
   assign wr_data     = chunk;
   assign rows_loaded = row_i;
   assign width_out   = width[COL_W-1:0];
   assign done        = (state == S_DONE);
   assign error       = (state == S_ERR);

endmodule
`default_nettype wire

// File: tb/tb_grid_loader.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_grid_loader                                             |
// | Description : Self-checking bench for grid_loader. Streams are checked   |
// |               against a line-oriented reference model of the loader.     |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_grid_loader;

   localparam int GRID_W = 16;
   localparam int TX_W   = 8;
   localparam int DEPTH  = 4;
   localparam int ADDR_W = 8;
   localparam int COL_W  = 8;
   localparam int NCH    = GRID_W / TX_W;

   logic              clock = 1'b0;
   logic              reset = 1'b0;
   logic              start = 1'b0;
   logic [7:0]        byte_in = 8'h00;
   logic              byte_valid = 1'b0;
   logic              byte_last = 1'b0;
   logic              byte_ready;
   logic              wr_en;
   logic [ADDR_W-1:0] wr_row;
   logic [COL_W-1:0]  wr_col;
   logic [TX_W-1:0]   wr_data;
   logic              wr_ack = 1'b0;
   logic [ADDR_W-1:0] rows_loaded;
   logic [COL_W-1:0]  width_out;
   logic              done;
   logic              error;

   always #5 clock = ~clock;

   grid_loader #(
      .GRID_W(GRID_W), .TX_W(TX_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W), .COL_W(COL_W)
   ) dut (
      .clock(clock), .reset(reset), .start(start),
      .byte_in(byte_in), .byte_valid(byte_valid), .byte_last(byte_last),
      .byte_ready(byte_ready),
      .wr_en(wr_en), .wr_row(wr_row), .wr_col(wr_col), .wr_data(wr_data),
      .wr_ack(wr_ack),
      .rows_loaded(rows_loaded), .width_out(width_out),
      .done(done), .error(error)
   );

   int n_checks = 0;
   int n_fail   = 0;

   logic [7:0] stream[$];
   int got_row[$], got_col[$], got_data[$];
   int exp_row[$], exp_col[$], exp_data[$];
   int exp_rows, exp_width;
   bit exp_err;

   // Expected writes for the 3x3 example grid (TX_W=8, GRID_W=16).
   localparam int G3_ROW[6]  = '{0, 0, 1, 1, 2, 2};
   localparam int G3_COL[6]  = '{0, 8, 0, 8, 0, 8};
   localparam int G3_DATA[6] = '{8'h05, 8'h00, 8'h02, 8'h00, 8'h07, 8'h00};

   // '^' in a directed string stands for a carriage return.
   task automatic load_str(input string s);
      stream.delete();
      for (int i = 0; i < s.len(); i++) begin
         if (s[i] == 8'h5E) stream.push_back(8'h0D);
         else               stream.push_back(s[i]);
      end
   endtask

   // Reference model: walk the stream line by line, build each row as a
   // GRID_W-bit vector and list the chunks the bank should receive.
   // A chunk is visible to the bank as soon as it is full; the rest of a
   // row (partial chunk plus zero padding) appears when the row ends.
   function automatic void model();
      logic [GRID_W-1:0] cells;
      logic [7:0]        c;
      int                n, row, width;
      bit                last;
      cells = '0; n = 0; row = 0; width = -1;
      exp_row.delete(); exp_col.delete(); exp_data.delete();
      exp_err = 1'b0;
      for (int i = 0; i < stream.size(); i++) begin
         c    = stream[i];
         last = (i == stream.size() - 1);
         if (c == 8'h40 || c == 8'h2E) begin
            if (n == GRID_W || row == DEPTH) begin exp_err = 1'b1; break; end
            cells[n] = (c == 8'h40);
            n++;
            if (n % TX_W == 0) begin
               exp_row.push_back(row);
               exp_col.push_back((n / TX_W - 1) * TX_W);
               exp_data.push_back(int'(cells[(n / TX_W - 1) * TX_W +: TX_W]));
            end
         end else if (c != 8'h0A && c != 8'h0D) begin
            exp_err = 1'b1;
            break;
         end
         if ((c == 8'h0A || last) && n > 0) begin
            if (width >= 0 && n != width) begin exp_err = 1'b1; break; end
            width = n;
            for (int k = n / TX_W; k < NCH; k++) begin
               exp_row.push_back(row);
               exp_col.push_back(k * TX_W);
               exp_data.push_back(int'(cells[k * TX_W +: TX_W]));
            end
            row++;
            n = 0;
            cells = '0;
         end
      end
      exp_rows  = row;
      exp_width = (width < 0) ? 0 : width;
   endfunction

   task automatic pulse_start();
      @(negedge clock);
      start = 1'b1; byte_valid = 1'b0; byte_last = 1'b0; wr_ack = 1'b0;
      @(negedge clock);
      start = 1'b0;
   endtask

   // mode 0: wr_ack tied high, 1: random wr_ack, 2: ack after 5 held cycles
   task automatic run_stream(input int mode, input string name);
      int idx, cyc, hold, p_row, p_col, p_data, nmin;
      bit pend, fin;
      idx = 0; cyc = 0; hold = 0; pend = 0; fin = 0;
      p_row = 0; p_col = 0; p_data = 0;
      got_row.delete(); got_col.delete(); got_data.delete();
      model();
      pulse_start();
      while (!fin && cyc < 3000) begin
         @(negedge clock);
         cyc++;
         if (done || error) begin
            fin = 1; byte_valid = 1'b0; byte_last = 1'b0; wr_ack = 1'b0;
         end else begin
            if (wr_en && pend) begin
               n_checks++;
               if (int'(wr_row) !== p_row || int'(wr_col) !== p_col || int'(wr_data) !== p_data) begin
                  n_fail++;
                  $display("FAIL %s hold_stable: row/col/data %0d/%0d/%0h required %0d/%0d/%0h",
                           name, wr_row, wr_col, wr_data, p_row, p_col, p_data);
               end
            end
            if (wr_en && mode == 2) begin
               n_checks++;
               if (byte_ready !== 1'b0) begin
                  n_fail++;
                  $display("FAIL %s ready_during_write: byte_ready=%b required 0", name, byte_ready);
               end
            end
            case (mode)
               0:       wr_ack = 1'b1;
               1:       wr_ack = ($urandom_range(0, 2) != 0);
               default: wr_ack = (hold >= 5);
            endcase
            if (idx < stream.size()) begin
               byte_valid = 1'b1;
               byte_in    = stream[idx];
               byte_last  = (idx == stream.size() - 1);
            end else begin
               byte_valid = 1'b0;
               byte_last  = 1'b0;
            end
            if (byte_valid && byte_ready) idx++;
            if (wr_en && wr_ack) begin
               got_row.push_back(int'(wr_row));
               got_col.push_back(int'(wr_col));
               got_data.push_back(int'(wr_data));
               pend = 0; hold = 0;
            end else if (wr_en) begin
               pend = 1; hold++;
               p_row = int'(wr_row); p_col = int'(wr_col); p_data = int'(wr_data);
            end else begin
               pend = 0; hold = 0;
            end
         end
      end
      byte_valid = 1'b0;
      byte_last  = 1'b0;
      if (!fin) begin
         n_checks++; n_fail++;
         $display("FAIL %s timeout: no done/error after %0d cycles", name, cyc);
      end
      n_checks++;
      if (got_data.size() !== exp_data.size()) begin
         n_fail++;
         $display("FAIL %s write_count: got %0d required %0d", name, got_data.size(), exp_data.size());
      end
      nmin = (got_data.size() < exp_data.size()) ? got_data.size() : exp_data.size();
      for (int i = 0; i < nmin; i++) begin
         n_checks++;
         if (got_row[i] !== exp_row[i] || got_col[i] !== exp_col[i] || got_data[i] !== exp_data[i]) begin
            n_fail++;
            $display("FAIL %s write%0d: row/col/data %0d/%0d/%0h required %0d/%0d/%0h",
                     name, i, got_row[i], got_col[i], got_data[i], exp_row[i], exp_col[i], exp_data[i]);
         end
      end
      n_checks++;
      if (int'(rows_loaded) !== exp_rows) begin
         n_fail++;
         $display("FAIL %s rows_loaded: got %0d required %0d", name, rows_loaded, exp_rows);
      end
      n_checks++;
      if (int'(width_out) !== exp_width) begin
         n_fail++;
         $display("FAIL %s width_out: got %0d required %0d", name, width_out, exp_width);
      end
      n_checks++;
      if (done !== !exp_err || error !== exp_err) begin
         n_fail++;
         $display("FAIL %s status: done/error %b/%b required %b/%b", name, done, error, !exp_err, exp_err);
      end
   endtask

   task automatic check_g3(input string name);
      n_checks++;
      if (got_data.size() !== 6) begin
         n_fail++;
         $display("FAIL %s g3_count: got %0d required 6", name, got_data.size());
      end else begin
         for (int i = 0; i < 6; i++) begin
            n_checks++;
            if (got_row[i] !== G3_ROW[i] || got_col[i] !== G3_COL[i] || got_data[i] !== G3_DATA[i]) begin
               n_fail++;
               $display("FAIL %s g3_write%0d: row/col/data %0d/%0d/%0h required %0d/%0d/%0h",
                        name, i, got_row[i], got_col[i], got_data[i], G3_ROW[i], G3_COL[i], G3_DATA[i]);
            end
         end
      end
      n_checks++;
      if (rows_loaded !== 8'd3 || width_out !== 8'd3 || done !== 1'b1) begin
         n_fail++;
         $display("FAIL %s g3_status: rows/width/done %0d/%0d/%b required 3/3/1",
                  name, rows_loaded, width_out, done);
      end
   endtask

   // Feed n '@' bytes, one per cycle, with the current wr_ack level.
   task automatic feed_rolls(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clock);
         byte_valid = 1'b1; byte_in = 8'h40; byte_last = 1'b0;
      end
      @(negedge clock);
      byte_valid = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (3) @(negedge clock);
      n_checks++;
      if (byte_ready !== 1'b0 || wr_en !== 1'b0 || done !== 1'b0 || error !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_flags: ready/wr_en/done/error %b/%b/%b/%b required 0/0/0/0",
                  byte_ready, wr_en, done, error);
      end
      n_checks++;
      if (wr_row !== '0 || wr_col !== '0 || wr_data !== '0 || rows_loaded !== '0 || width_out !== '0) begin
         n_fail++;
         $display("FAIL reset_values: row/col/data/rows/width %0d/%0d/%0h/%0d/%0d required all 0",
                  wr_row, wr_col, wr_data, rows_loaded, width_out);
      end
      reset = 1'b0;
      @(negedge clock);
   endtask

   task automatic test_grid3();
      load_str("@.@\n.@.\n@@@\n");
      run_stream(0, "grid3");
      check_g3("grid3");
   endtask

   task automatic test_ack_delay();
      load_str("@@@@@@@@@@\n");
      run_stream(2, "ack_delay");
      n_checks++;
      if (got_data.size() !== 2 || got_data[0] !== 8'hFF || got_data[1] !== 8'h03 ||
          got_col[0] !== 0 || got_col[1] !== 8) begin
         n_fail++;
         $display("FAIL ack_delay_chunks: %0d writes, first data %0h, required FF@0 then 03@8",
                  got_data.size(), (got_data.size() > 0) ? got_data[0] : -1);
      end
   endtask

   task automatic test_no_trailing();
      load_str(".@@\n@.@");
      run_stream(1, "no_trailing");
      n_checks++;
      if (got_data.size() !== 4 || got_data[0] !== 8'h06 || got_data[2] !== 8'h05 || done !== 1'b1) begin
         n_fail++;
         $display("FAIL no_trailing_flush: %0d writes, done=%b required 4 writes (06,00,05,00), done=1",
                  got_data.size(), done);
      end
   endtask

   task automatic test_width_error();
      load_str("@@@\n@@\n");
      run_stream(0, "width_err");
      n_checks++;
      if (byte_ready !== 1'b0 || wr_en !== 1'b0) begin
         n_fail++;
         $display("FAIL width_err_idle: ready/wr_en %b/%b required 0/0", byte_ready, wr_en);
      end
      pulse_start();
      n_checks++;
      if (error !== 1'b0 || byte_ready !== 1'b1 || rows_loaded !== '0) begin
         n_fail++;
         $display("FAIL start_clears_error: error/ready/rows %b/%b/%0d required 0/1/0",
                  error, byte_ready, rows_loaded);
      end
   endtask

   task automatic test_bad_char();
      logic [7:0] seq [3];
      seq = '{8'h40, 8'h2E, 8'h78};
      pulse_start();
      wr_ack = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clock);
         byte_valid = 1'b1; byte_in = seq[i]; byte_last = 1'b0;
      end
      n_checks++;
      if (error !== 1'b0) begin
         n_fail++;
         $display("FAIL bad_char_early: error=%b before bad byte accepted, required 0", error);
      end
      @(negedge clock);
      byte_valid = 1'b0;
      n_checks++;
      if (error !== 1'b1 || byte_ready !== 1'b0 || wr_en !== 1'b0) begin
         n_fail++;
         $display("FAIL bad_char: error/ready/wr_en %b/%b/%b required 1/0/0", error, byte_ready, wr_en);
      end
   endtask

   task automatic test_depth();
      load_str("@\n@\n@\n@\n@\n");
      run_stream(1, "depth");
   endtask

   task automatic test_crlf_blank();
      load_str("@.@^\n^\n.@.^\n\n@@@^\n");
      run_stream(1, "crlf_blank");
      check_g3("crlf_blank");
   endtask

   task automatic test_abort_write(input bit use_reset);
      pulse_start();
      wr_ack = 1'b0;
      feed_rolls(TX_W);
      n_checks++;
      if (wr_en !== 1'b1 || wr_data !== 8'hFF || byte_ready !== 1'b0) begin
         n_fail++;
         $display("FAIL abort_pending: wr_en/data/ready %b/%0h/%b required 1/FF/0", wr_en, wr_data, byte_ready);
      end
      if (use_reset) reset = 1'b1;
      else           start = 1'b1;
      @(negedge clock);
      reset = 1'b0;
      start = 1'b0;
      n_checks++;
      if (wr_en !== 1'b0 || wr_data !== '0 || rows_loaded !== '0 || byte_ready !== !use_reset) begin
         n_fail++;
         $display("FAIL abort_%s: wr_en/data/rows/ready %b/%0h/%0d/%b required 0/0/0/%b",
                  use_reset ? "reset" : "start", wr_en, wr_data, rows_loaded, byte_ready, !use_reset);
      end
   endtask

   task automatic gen_random();
      int rows, w, rw;
      logic [7:0] b;
      stream.delete();
      rows = ($urandom_range(0, 9) == 0) ? DEPTH + 1 : $urandom_range(1, DEPTH);
      w    = $urandom_range(1, GRID_W);
      for (int r = 0; r < rows; r++) begin
         rw = w;
         if ($urandom_range(0, 7) == 0) rw = ($urandom_range(0, 1) != 0) ? w + 1 : w - 1;
         if (rw < 1) rw = 1;
         if ($urandom_range(0, 5) == 0) stream.push_back(8'h0A);
         for (int c = 0; c < rw; c++) begin
            b = ($urandom_range(0, 1) != 0) ? 8'h40 : 8'h2E;
            if ($urandom_range(0, 59) == 0) b = 8'h78;
            stream.push_back(b);
         end
         if (r < rows - 1 || $urandom_range(0, 1) != 0) begin
            if ($urandom_range(0, 1) != 0) stream.push_back(8'h0D);
            stream.push_back(8'h0A);
         end
      end
   endtask

   task automatic test_random();
      for (int t = 0; t < 30; t++) begin
         gen_random();
         run_stream(($urandom_range(0, 3) == 0) ? 0 : 1, "random");
      end
   endtask

   initial begin
      test_reset();
      test_grid3();
      test_ack_delay();
      test_no_trailing();
      test_width_error();
      test_bad_char();
      test_depth();
      test_crlf_blank();
      test_abort_write(1'b1);
      test_abort_write(1'b0);
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #5000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
`default_nettype wire
